// File: rtl/spi_slave_shift_pkg.sv
// Shared constants for the SPI responder shift engine: default sizes and FSM encodings.
package spi_slave_shift_pkg;

    localparam int SPI_SLV_MAX_CHAR = 32;
    localparam int SPI_SLV_LEN_BITS = 5;

    typedef logic [0:0] spi_slv_state_t;

    localparam spi_slv_state_t SPI_SLV_IDLE   = 1'b0;
    localparam spi_slv_state_t SPI_SLV_ACTIVE = 1'b1;

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchronisers for the SPI pins plus sclk leading/trailing edge detection.
module spi_slave_sync (
    input  logic wb_clk_in,
    input  logic wb_rst_n,
    input  logic cpol,
    input  logic sclk_in,
    input  logic ss_n_in,
    input  logic mosi_in,
    output logic ss_n_s,
    output logic mosi_s,
    output logic lead_edge,
    output logic trail_edge
);

    logic sclk_m;
    logic sclk_s;
    logic sclk_d;
    logic ss_n_m;
    logic mosi_m;

    // ss_n syncs reset to the deselected level so reset never looks like a select
    always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sclk_m <= 1'b0;
            sclk_s <= 1'b0;
            sclk_d <= 1'b0;
            ss_n_m <= 1'b1;
            ss_n_s <= 1'b1;
            mosi_m <= 1'b0;
            mosi_s <= 1'b0;
        end else begin
            sclk_m <= sclk_in;
            sclk_s <= sclk_m;
            sclk_d <= sclk_s;
            ss_n_m <= ss_n_in;
            ss_n_s <= ss_n_m;
            mosi_m <= mosi_in;
            mosi_s <= mosi_m;
        end
    end

    assign lead_edge  = (sclk_d == cpol) && (sclk_s != cpol);
    assign trail_edge = (sclk_d != cpol) && (sclk_s == cpol);

endmodule

// File: rtl/spi_slave_shift.sv
// SPI responder shift engine: receives on mosi, transmits on miso for all cpol/cpha modes,
// with a single-entry TX holding buffer towards the register side.
module spi_slave_shift
    import spi_slave_shift_pkg::*;
#(
    parameter int MAX_CHAR = SPI_SLV_MAX_CHAR,
    parameter int LEN_BITS = SPI_SLV_LEN_BITS
) (
    input  logic                wb_clk_in,
    input  logic                wb_rst_n,
    input  logic                enable,
    input  logic                cpol,
    input  logic                cpha,
    input  logic                lsb,
    input  logic [LEN_BITS-1:0] char_len,
    input  logic [MAX_CHAR-1:0] tx_data,
    input  logic                tx_load,
    output logic                tx_ready,
    output logic [MAX_CHAR-1:0] rx_data,
    output logic                rx_valid,
    output logic                tx_underrun,
    output logic                busy,
    input  logic                sclk_in,
    input  logic                ss_n_in,
    input  logic                mosi_in,
    output logic                miso_out,
    output logic                miso_oe
);

    spi_slv_state_t      state;
    logic                ss_n_s;
    logic                ss_n_q;
    logic                mosi_s;
    logic                lead_edge;
    logic                trail_edge;
    logic                sample_edge;
    logic                shift_edge;
    logic [MAX_CHAR-1:0] tx_buf;
    logic                tx_full;
    logic [MAX_CHAR-1:0] tx_sr;
    logic                skip_shift;
    logic [MAX_CHAR-1:0] rx_sr;
    logic [MAX_CHAR-1:0] rx_next;
    logic [LEN_BITS:0]   bit_cnt;
    logic [LEN_BITS:0]   cnt_next;
    logic [LEN_BITS:0]   eff_len;
    logic [LEN_BITS-1:0] msb_idx;
    logic                cur_bit;
    logic                miso_hold;
    logic                stay_active;
    logic                char_done;
    logic                start_char;
    logic                reload;
    logic                tx_advance;

    spi_slave_sync u_sync (
        .wb_clk_in  (wb_clk_in),
        .wb_rst_n   (wb_rst_n),
        .cpol       (cpol),
        .sclk_in    (sclk_in),
        .ss_n_in    (ss_n_in),
        .mosi_in    (mosi_in),
        .ss_n_s     (ss_n_s),
        .mosi_s     (mosi_s),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge)
    );

    assign eff_len     = (char_len == '0) ? (LEN_BITS+1)'(MAX_CHAR) : {1'b0, char_len};
    assign msb_idx     = LEN_BITS'(eff_len - 1'b1);
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge : trail_edge;
    assign cnt_next    = bit_cnt + 1'b1;

    assign stay_active = (state == SPI_SLV_ACTIVE) && enable && !ss_n_s;
    assign char_done   = stay_active && sample_edge && (cnt_next == eff_len);
    assign start_char  = (state == SPI_SLV_IDLE) && enable && ss_n_q && !ss_n_s;
    assign reload      = start_char || char_done;
    assign tx_advance  = stay_active && !sample_edge && shift_edge && !skip_shift;

    // LSB-first inserts at the top of the active window so the result ends right-aligned
    assign rx_next = lsb ? ((rx_sr >> 1) | (MAX_CHAR'(mosi_s) << msb_idx))
                         : {rx_sr[MAX_CHAR-2:0], mosi_s};

    assign cur_bit  = lsb ? tx_sr[0] : tx_sr[msb_idx];
    assign miso_oe  = enable && !ss_n_s;
    assign miso_out = miso_oe ? cur_bit : miso_hold;
    assign busy     = (state == SPI_SLV_ACTIVE) && !ss_n_s;
    assign tx_ready = !tx_full;

    always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= SPI_SLV_IDLE;
            ss_n_q    <= 1'b1;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            miso_hold <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            ss_n_q    <= ss_n_s;
            miso_hold <= miso_out;
            case (state)
                SPI_SLV_IDLE: begin
                    if (start_char) begin
                        state   <= SPI_SLV_ACTIVE;
                        bit_cnt <= '0;
                        rx_sr   <= '0;
                    end
                end
                default: begin
                    if (!stay_active) begin
                        state   <= SPI_SLV_IDLE;
                        bit_cnt <= '0;
                        rx_sr   <= '0;
                    end else if (char_done) begin
                        rx_data  <= rx_next;
                        rx_valid <= 1'b1;
                        bit_cnt  <= '0;
                        rx_sr    <= '0;
                    end else if (sample_edge) begin
                        rx_sr   <= rx_next;
                        bit_cnt <= cnt_next;
                    end
                end
            endcase
        end
    end

    // A reload after a completed character always already presents bit 0, so the
    // following shift edge is skipped in both cpha modes; at select only cpha=1 needs it.
    always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            tx_sr       <= '0;
            skip_shift  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (reload) begin
                tx_sr       <= tx_full ? tx_buf : '0;
                tx_underrun <= !tx_full;
                tx_full     <= 1'b0;
                skip_shift  <= char_done ? 1'b1 : cpha;
            end else if (tx_advance) begin
                tx_sr <= lsb ? (tx_sr >> 1) : (tx_sr << 1);
            end else if (stay_active && shift_edge) begin
                skip_shift <= 1'b0;
            end
            if (tx_load && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_shift.sv
// Directed bench for spi_slave_shift: acts as SPI master and checks rx/tx data and status.
module tb_spi_slave_shift;

    localparam int HALF = 80;

    logic        wb_clk_in = 1'b0;
    logic        wb_rst_n  = 1'b0;
    logic        enable    = 1'b0;
    logic        cpol      = 1'b0;
    logic        cpha      = 1'b0;
    logic        lsb       = 1'b0;
    logic [4:0]  char_len  = 5'd8;
    logic [31:0] tx_data   = '0;
    logic        tx_load   = 1'b0;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        tx_underrun;
    logic        busy;
    logic        sclk_in   = 1'b0;
    logic        ss_n_in   = 1'b1;
    logic        mosi_in   = 1'b0;
    logic        miso_out;
    logic        miso_oe;

    int          checks     = 0;
    int          errors     = 0;
    int          rx_pulses  = 0;
    int          underruns  = 0;
    logic [31:0] rx_log[$];

    spi_slave_shift dut (
        .wb_clk_in   (wb_clk_in),
        .wb_rst_n    (wb_rst_n),
        .enable      (enable),
        .cpol        (cpol),
        .cpha        (cpha),
        .lsb         (lsb),
        .char_len    (char_len),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .busy        (busy),
        .sclk_in     (sclk_in),
        .ss_n_in     (ss_n_in),
        .mosi_in     (mosi_in),
        .miso_out    (miso_out),
        .miso_oe     (miso_oe)
    );

    always #5 wb_clk_in = ~wb_clk_in;

    always @(negedge wb_clk_in) begin
        if (rx_valid) begin
            rx_pulses++;
            rx_log.push_back(rx_data);
        end
        if (tx_underrun) underruns++;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_tx(input logic [31:0] d);
        tx_data = d;
        tx_load = 1'b1;
        #10;
        tx_load = 1'b0;
    endtask

    // Master side: drive nbits of a len-bit character, capture what the responder sends.
    task automatic apply_stimulus(input logic [31:0] mo, input int len, input int nbits,
                                  output logic [31:0] mi);
        int idx;
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = lsb ? i : len - 1 - i;
            if (!cpha) begin
                mosi_in = mo[idx];
                #HALF;
                sclk_in = ~cpol;
                mi[idx] = miso_out;
                #HALF;
                sclk_in = cpol;
            end else begin
                #HALF;
                sclk_in = ~cpol;
                mosi_in = mo[idx];
                #HALF;
                sclk_in = cpol;
                mi[idx] = miso_out;
            end
        end
        #HALF;
    endtask

    initial begin
        logic [31:0] got;
        int base_rx;
        int base_ur;

        // Reset values
        #20;
        check_output("rst_tx_ready", 32'(tx_ready), 32'd1);
        check_output("rst_rx_data", rx_data, 32'd0);
        check_output("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_output("rst_underrun", 32'(tx_underrun), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_miso", 32'(miso_out), 32'd0);
        check_output("rst_miso_oe", 32'(miso_oe), 32'd0);
        wb_rst_n = 1'b1;
        enable   = 1'b1;
        #40;

        // Mode 0, MSB first, 8 bits
        $display("[TB] mode 0 transfer");
        cpol = 0; cpha = 0; lsb = 0; char_len = 5'd8;
        load_tx(32'hA5);
        check_output("m0_tx_ready_full", 32'(tx_ready), 32'd0);
        base_rx = rx_pulses; base_ur = underruns;
        ss_n_in = 1'b0;
        #100;
        check_output("m0_tx_ready_after_ss", 32'(tx_ready), 32'd1);
        check_output("m0_busy", 32'(busy), 32'd1);
        check_output("m0_miso_oe", 32'(miso_oe), 32'd1);
        check_output("m0_no_underrun", 32'(underruns - base_ur), 32'd0);
        apply_stimulus(32'h3C, 8, 8, got);
        check_output("m0_miso", got, 32'hA5);
        check_output("m0_rx_pulses", 32'(rx_pulses - base_rx), 32'd1);
        check_output("m0_rx_data", rx_data, 32'h3C);
        ss_n_in = 1'b1;
        #100;
        check_output("m0_busy_off", 32'(busy), 32'd0);
        check_output("m0_oe_off", 32'(miso_oe), 32'd0);

        // Mode 3, LSB first, 32 bits
        $display("[TB] mode 3 transfer");
        cpol = 1; cpha = 1; lsb = 1; char_len = 5'd0;
        sclk_in = 1'b1;
        #100;
        load_tx(32'hDEADBEEF);
        base_rx = rx_pulses;
        ss_n_in = 1'b0;
        #100;
        apply_stimulus(32'h12345678, 32, 32, got);
        check_output("m3_miso", got, 32'hDEADBEEF);
        check_output("m3_rx_pulses", 32'(rx_pulses - base_rx), 32'd1);
        check_output("m3_rx_data", rx_data, 32'h12345678);
        ss_n_in = 1'b1;
        #100;

        // Back-to-back characters under one select
        $display("[TB] back-to-back transfer");
        cpol = 0; cpha = 0; lsb = 0; char_len = 5'd8;
        sclk_in = 1'b0;
        #100;
        load_tx(32'h11);
        base_rx = rx_pulses; base_ur = underruns;
        ss_n_in = 1'b0;
        #100;
        load_tx(32'h22);
        check_output("b2b_tx_ready_full", 32'(tx_ready), 32'd0);
        apply_stimulus(32'hC3, 8, 8, got);
        check_output("b2b_miso_1", got, 32'h11);
        check_output("b2b_no_underrun", 32'(underruns - base_ur), 32'd0);
        apply_stimulus(32'h7E, 8, 8, got);
        check_output("b2b_miso_2", got, 32'h22);
        check_output("b2b_rx_pulses", 32'(rx_pulses - base_rx), 32'd2);
        check_output("b2b_rx_1", rx_log[base_rx], 32'hC3);
        check_output("b2b_rx_2", rx_log[base_rx + 1], 32'h7E);
        ss_n_in = 1'b1;
        #100;

        // Underrun: nothing loaded before select
        $display("[TB] underrun transfer");
        base_rx = rx_pulses; base_ur = underruns;
        ss_n_in = 1'b0;
        #100;
        check_output("ur_pulse", 32'(underruns - base_ur), 32'd1);
        apply_stimulus(32'h96, 8, 8, got);
        check_output("ur_miso_zero", got, 32'h00);
        check_output("ur_rx_data", rx_data, 32'h96);
        check_output("ur_rx_pulses", 32'(rx_pulses - base_rx), 32'd1);
        ss_n_in = 1'b1;
        #100;

        // Abort after 5 of 8 bits, then a full character
        $display("[TB] abort transfer");
        base_rx = rx_pulses;
        ss_n_in = 1'b0;
        #100;
        apply_stimulus(32'hE7, 8, 5, got);
        ss_n_in = 1'b1;
        #100;
        check_output("ab_no_rx", 32'(rx_pulses - base_rx), 32'd0);
        check_output("ab_busy", 32'(busy), 32'd0);
        check_output("ab_miso_oe", 32'(miso_oe), 32'd0);
        load_tx(32'h3A);
        ss_n_in = 1'b0;
        #100;
        apply_stimulus(32'hE7, 8, 8, got);
        check_output("ab_next_miso", got, 32'h3A);
        check_output("ab_next_rx", rx_data, 32'hE7);
        check_output("ab_next_pulses", 32'(rx_pulses - base_rx), 32'd1);
        ss_n_in = 1'b1;
        #100;

        // Reset mid-character, then a clean mode 1 transfer
        $display("[TB] reset mid-character");
        cpol = 0; cpha = 1; lsb = 0; char_len = 5'd8;
        load_tx(32'hF0);
        ss_n_in = 1'b0;
        #100;
        apply_stimulus(32'hFF, 8, 3, got);
        wb_rst_n = 1'b0;
        #1;
        check_output("mr_tx_ready", 32'(tx_ready), 32'd1);
        check_output("mr_rx_data", rx_data, 32'd0);
        check_output("mr_rx_valid", 32'(rx_valid), 32'd0);
        check_output("mr_busy", 32'(busy), 32'd0);
        check_output("mr_miso", 32'(miso_out), 32'd0);
        check_output("mr_miso_oe", 32'(miso_oe), 32'd0);
        #9;
        ss_n_in = 1'b1;
        sclk_in = 1'b0;
        #20;
        wb_rst_n = 1'b1;
        #40;
        load_tx(32'hC3);
        base_rx = rx_pulses;
        ss_n_in = 1'b0;
        #100;
        apply_stimulus(32'h5A, 8, 8, got);
        check_output("m1_miso", got, 32'hC3);
        check_output("m1_rx_data", rx_data, 32'h5A);
        check_output("m1_rx_pulses", 32'(rx_pulses - base_rx), 32'd1);
        ss_n_in = 1'b1;
        #100;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
